// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. in_ready is registered, so downstream stalls never reach upstream
// combinationally. Flush empties the stage and shows NOP_INSTR downstream.
module pipe_stage_skid #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'b0000100000000000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic               err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
  logic [DATA_W-1:0]    main_data_q, main_data_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 err_q, err_d;
  logic                 stall_q, stall_d;
  logic [INSTR_W-1:0]   prev_instr_q;
  logic [DATA_W-1:0]    prev_data_q;
  logic                 accept_c;
  logic                 rel_c;
  logic                 changed_c;

  // State and datapath registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_data_q  <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_data_q  <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      prev_instr_q <= '0;
      prev_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_data_q  <= main_data_d;
      skid_instr_q <= skid_instr_d;
      skid_data_q  <= skid_data_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      err_q        <= err_d;
      stall_q      <= stall_d;
      prev_instr_q <= in_instr;
      prev_data_q  <= in_data;
    end
  end

  // Next-state, datapath steering, and protocol checking
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_data_d  = main_data_q;
    skid_instr_d = skid_instr_q;
    skid_data_d  = skid_data_q;
    accept_c     = in_valid & in_ready_q;
    rel_c        = out_valid_q & out_ready;
    changed_c    = (in_instr != prev_instr_q) || (in_data != prev_data_q);

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            state_d      = ONE;
            main_instr_d = in_instr;
            main_data_d  = in_data;
          end
        end
        ONE: begin
          if (accept_c && rel_c) begin
            main_instr_d = in_instr;
            main_data_d  = in_data;
          end else if (accept_c) begin
            state_d      = TWO;
            skid_instr_d = in_instr;
            skid_data_d  = in_data;
          end else if (rel_c) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (rel_c) begin
            state_d      = ONE;
            main_instr_d = skid_instr_q;
            main_data_d  = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // An empty stage presents a masked head, not just an invalid one
    if (state_d == EMPTY) begin
      main_instr_d = NOP_INSTR;
      main_data_d  = '0;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);

    // Flushed offers are discarded, so the producer may drop them freely
    stall_d = in_valid & ~in_ready_q & ~flush;
    err_d   = stall_q & (~in_valid | changed_c) & ~flush;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = main_instr_q;
  assign out_data  = main_data_q;
  assign occupancy = 2'(state_q);
  assign err       = err_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush,
// simultaneous accept/release and protocol-error reporting.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned INSTR_W = 16;
  localparam logic [15:0] NOP     = 16'h0800;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_data;
  logic [1:0]        occupancy;
  logic              err;

  int errors = 0;
  int checks = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_data  (out_data),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Head/valid/occupancy/in_ready snapshot
  task automatic chk_state(input string tag, input logic v, input logic [15:0] ins,
                           input logic [63:0] dat, input logic [1:0] occ, input logic rdy);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ins));
    chk({tag, ".out_data"},  out_data, dat);
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    chk({tag, ".in_ready"},  64'(in_ready), 64'(rdy));
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic [63:0] dat);
    in_valid = v;
    in_instr = ins;
    in_data  = dat;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h1234, 64'hDEAD_BEEF_0000_1111);

    // Reset held two cycles with a pending offer
    tick(); tick();
    chk_state("reset", 1'b0, NOP, 64'h0, 2'd0, 1'b1);
    chk("reset.err", 64'(err), 64'h0);

    rst = 1'b1;
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk_state("idle", 1'b0, NOP, 64'h0, 2'd0, 1'b1);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), {48'h5A5A_0000_FFFF, 16'(i)});
      tick();
      chk_state($sformatf("stream%0d", i), 1'b1, 16'(i), {48'h5A5A_0000_FFFF, 16'(i)}, 2'd1, 1'b1);
    end
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk_state("stream_drain", 1'b0, NOP, 64'h0, 2'd0, 1'b1);

    // Back-pressure fills the skid
    out_ready = 1'b0;
    drive(1'b1, 16'hA000, 64'hAAAA_0000_0000_000A);
    tick();
    chk_state("bp_a", 1'b1, 16'hA000, 64'hAAAA_0000_0000_000A, 2'd1, 1'b1);
    drive(1'b1, 16'hB000, 64'hBBBB_0000_0000_000B);
    tick();
    chk_state("bp_b", 1'b1, 16'hA000, 64'hAAAA_0000_0000_000A, 2'd2, 1'b0);
    drive(1'b0, 16'h0, 64'h0);
    tick(); tick(); tick();
    chk_state("bp_hold", 1'b1, 16'hA000, 64'hAAAA_0000_0000_000A, 2'd2, 1'b0);
    chk("bp_hold.err", 64'(err), 64'h0);
    out_ready = 1'b1;
    tick();
    chk_state("bp_rel_a", 1'b1, 16'hB000, 64'hBBBB_0000_0000_000B, 2'd1, 1'b1);
    tick();
    chk_state("bp_rel_b", 1'b0, NOP, 64'h0, 2'd0, 1'b1);

    // Flush with full skid and an incoming offer C
    out_ready = 1'b0;
    drive(1'b1, 16'hA100, 64'h1);
    tick();
    drive(1'b1, 16'hB100, 64'h2);
    tick();
    chk("fl_full.occupancy", 64'(occupancy), 64'd2);
    drive(1'b1, 16'hC000, 64'hCCCC_CCCC_CCCC_CCCC);
    flush = 1'b1;
    tick();
    chk_state("flush_full", 1'b0, NOP, 64'h0, 2'd0, 1'b1);
    chk("flush_full.err", 64'(err), 64'h0);
    flush = 1'b0;
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk_state("flush_after", 1'b0, NOP, 64'h0, 2'd0, 1'b1);
    chk("flush_after.err", 64'(err), 64'h0);

    // Accept and release together in ONE
    drive(1'b1, 16'hD000, 64'hD);
    tick();
    chk_state("one_d", 1'b1, 16'hD000, 64'hD, 2'd1, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 16'hE000, 64'hE);
    tick();
    chk_state("one_e", 1'b1, 16'hE000, 64'hE, 2'd1, 1'b1);
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk_state("one_drain", 1'b0, NOP, 64'h0, 2'd0, 1'b1);

    // Same pattern under flush: E is dropped
    out_ready = 1'b0;
    drive(1'b1, 16'hD000, 64'hD);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 16'hE000, 64'hE);
    flush = 1'b1;
    tick();
    chk_state("one_flush", 1'b0, NOP, 64'h0, 2'd0, 1'b1);
    flush = 1'b0;
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk_state("one_flush_after", 1'b0, NOP, 64'h0, 2'd0, 1'b1);

    // Protocol error: stalled F withdrawn
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 64'h11);
    tick();
    drive(1'b1, 16'h2222, 64'h22);
    tick();
    drive(1'b1, 16'hF000, 64'hF);
    tick();
    chk("perr_stall.err", 64'(err), 64'h0);
    tick();
    chk("perr_steady.err", 64'(err), 64'h0);
    drive(1'b0, 16'h0, 64'h0);
    tick();
    chk("perr_withdraw.err", 64'(err), 64'h1);
    chk_state("perr_state", 1'b1, 16'h1111, 64'h11, 2'd2, 1'b0);
    tick();
    chk("perr_pulse_end.err", 64'(err), 64'h0);

    // Changing a stalled entry is also an error
    drive(1'b1, 16'hF000, 64'hF);
    tick();
    drive(1'b1, 16'hF000, 64'h10);
    tick();
    chk("perr_change.err", 64'(err), 64'h1);

    // Withdrawal under flush is suppressed
    drive(1'b1, 16'hF000, 64'hF);
    tick();
    drive(1'b0, 16'h0, 64'h0);
    flush = 1'b1;
    tick();
    chk("perr_flush.err", 64'(err), 64'h0);
    chk_state("perr_flush", 1'b0, NOP, 64'h0, 2'd0, 1'b1);
    flush = 1'b0;
    tick();
    chk("perr_flush_after.err", 64'(err), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
